// File: rtl/conv_pool_bin_if.sv
// Stream bundle between the conv stage, this pooling/binarize stage and the next layer.
interface conv_pool_bin_if #(
  parameter int DATA_W = 16
);
  logic                     state;
  logic signed [DATA_W-1:0] thresh;
  logic signed [DATA_W-1:0] din;
  logic                     ivalid;
  logic                     idone;
  logic signed [DATA_W-1:0] pout;
  logic                     bout;
  logic                     pvalid;
  logic                     odone;

  modport master (
    output state, thresh, din, ivalid, idone,
    input  pout, bout, pvalid, odone
  );

  modport slave (
    input  state, thresh, din, ivalid, idone,
    output pout, bout, pvalid, odone
  );
endinterface

// File: rtl/conv_pool_bin.sv
// 2x2 stride-2 max pooling over a row-major conv output stream, followed by
// threshold binarization. Even rows fold column pairs into a half-width line
// buffer; odd rows combine with that buffer and emit one pooled pixel per pair.
module conv_pool_bin #(
  parameter int DATA_W = 16,
  parameter int W0     = 26,
  parameter int W1     = 11,
  parameter int BUF_D  = 13
) (
  input  logic           clk,
  input  logic           rstn,
  conv_pool_bin_if.slave bus
);

  localparam int WMAX = (W0 > W1) ? W0 : W1;
  localparam int CW   = $clog2(WMAX + 1);
  localparam logic [CW-1:0] W0_C = CW'(W0);
  localparam logic [CW-1:0] W1_C = CW'(W1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } fsm_t;

  fsm_t                     st_reg, st_next;
  logic [CW-1:0]            col_reg, col_next;
  logic [CW-1:0]            w_reg;
  logic [CW-1:0]            c, w_cur;
  logic signed [DATA_W-1:0] a_reg;
  logic signed [DATA_W-1:0] lb_rd, pair_max, top_max;
  logic signed [DATA_W-1:0] pout_reg;
  logic                     bout_reg, pvalid_reg, odone_reg;
  logic                     last_col, odd_row, emit;

  // Half-width line buffer: small, so read asynchronously (distributed RAM).
  logic signed [DATA_W-1:0] linebuf [0:BUF_D-1];

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] x,
    input logic signed [DATA_W-1:0] y
  );
    return (x >= y) ? x : y;
  endfunction

  // Current column/width view; in IDLE the arriving sample is even row, col 0.
  always_comb begin
    c        = (st_reg == IDLE) ? '0 : col_reg;
    w_cur    = (st_reg == IDLE) ? (bus.state ? W1_C : W0_C) : w_reg;
    last_col = (c == w_cur - CW'(1));
    odd_row  = (st_reg == ODD);
    lb_rd    = linebuf[c[CW-1:1]];
    pair_max = smax(a_reg, bus.din);
    top_max  = smax(lb_rd, bus.din);
    emit     = bus.ivalid && odd_row && c[0];
  end

  // Next-state and column counter; idone overrides to close the frame.
  always_comb begin
    st_next  = st_reg;
    col_next = col_reg;
    if (bus.ivalid) begin
      col_next = last_col ? '0 : c + CW'(1);
      case (st_reg)
        IDLE:    st_next = last_col ? ODD : EVEN;
        EVEN:    st_next = last_col ? ODD : EVEN;
        ODD:     st_next = last_col ? EVEN : ODD;
        default: st_next = IDLE;
      endcase
    end
    if (bus.idone) begin
      st_next  = IDLE;
      col_next = '0;
    end
  end

  // FSM state and column register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_reg  <= IDLE;
      col_reg <= '0;
    end else begin
      st_reg  <= st_next;
      col_reg <= col_next;
    end
  end

  // Datapath: width latch, pair register and registered pooled/binarized outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_reg      <= W0_C;
      a_reg      <= '0;
      pout_reg   <= '0;
      bout_reg   <= 1'b0;
      pvalid_reg <= 1'b0;
      odone_reg  <= 1'b0;
    end else begin
      pvalid_reg <= emit;
      odone_reg  <= bus.idone;
      if (emit) begin
        pout_reg <= pair_max;
        bout_reg <= (pair_max >= bus.thresh);
      end
      if (bus.ivalid) begin
        if (st_reg == IDLE)
          w_reg <= w_cur;
        if (!c[0])
          a_reg <= odd_row ? top_max : bus.din;
      end
    end
  end

  // Even rows store the horizontal max of each column pair.
  always_ff @(posedge clk) begin
    if (bus.ivalid && !odd_row && c[0])
      linebuf[c[CW-1:1]] <= pair_max;
  end

  assign bus.pout   = pout_reg;
  assign bus.bout   = bout_reg;
  assign bus.pvalid = pvalid_reg;
  assign bus.odone  = odone_reg;

endmodule
